// File: rtl/axi_wr_fifo_sink.sv
// Write-only FIFO port behind the AXI write subordinate's component interface.
// Optional macro CALIPTRA_AXI_WR_FIFO_PARTIAL_EN: accept partial strobes and expose o_strb.
module axi_wr_fifo_sink #(
   parameter int unsigned    AW        = 32,
   parameter int unsigned    DW        = 32,
   parameter int unsigned    BC        = DW/8,
   parameter int unsigned    IW        = 1,
   parameter int unsigned    DEPTH     = 8,
   parameter logic [AW-1:0]  BASE_ADDR = 'h0000_0100,
   parameter int unsigned    WIN_BYTES = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       dv,
   input  logic [AW-1:0]              addr,
   input  logic [IW-1:0]              id,
   input  logic [DW-1:0]              wdata,
   input  logic [BC-1:0]              wstrb,
   input  logic                       last,
   output logic                       hld,
   output logic                       err,
   input  logic                       flush,
   output logic                       o_valid,
   output logic [DW-1:0]              o_data,
   output logic                       o_last,
   output logic [IW-1:0]              o_id,
`ifdef CALIPTRA_AXI_WR_FIFO_PARTIAL_EN
   output logic [BC-1:0]              o_strb,
`endif
   input  logic                       i_ready,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic                       full,
   output logic                       empty
);

   localparam int unsigned   PW       = $clog2(DEPTH);
   localparam int unsigned   LW       = $clog2(DEPTH+1);
   localparam logic [AW-1:0] WIN_MASK = ~(AW'(WIN_BYTES - 1));

   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [LW-1:0] level_q, level_d;

   logic [DW-1:0] mem_data_q [DEPTH];
   logic          mem_last_q [DEPTH];
   logic [IW-1:0] mem_id_q   [DEPTH];

   logic in_win, strb_ok, push_req, bad, push, pop;

   assign in_win = (addr & WIN_MASK) == BASE_ADDR;

`ifdef CALIPTRA_AXI_WR_FIFO_PARTIAL_EN
   logic [BC-1:0] mem_strb_q [DEPTH];

   // An all-zero strobe inside the window is a silent no-op, not an error.
   assign strb_ok = |wstrb;
   assign bad     = dv && !in_win;
   assign o_strb  = mem_strb_q[rptr_q];

   always_ff @(posedge clk) begin
      if (push) mem_strb_q[wptr_q] <= wstrb;
   end
`else
   assign strb_ok = &wstrb;
   assign bad     = dv && !(in_win && strb_ok);
`endif

   assign push_req = dv && in_win && strb_ok;
   // Stall depends only on registered full; a same-cycle pop never releases it.
   assign hld      = (push_req && full) || (dv && flush);
   assign err      = bad && !hld;
   assign push     = push_req && !hld;
   assign pop      = o_valid && i_ready && !flush;

   assign level   = level_q;
   assign full    = level_q == LW'(DEPTH);
   assign empty   = level_q == '0;
   assign o_valid = !empty;
   assign o_data  = mem_data_q[rptr_q];
   assign o_last  = mem_last_q[rptr_q];
   assign o_id    = mem_id_q[rptr_q];

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      level_d = level_q;
      if (flush) begin
         wptr_d  = '0;
         rptr_d  = '0;
         level_d = '0;
      end else begin
         if (push) wptr_d = wptr_q + PW'(1);
         if (pop)  rptr_d = rptr_q + PW'(1);
         level_d = level_q + LW'(push) - LW'(pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_data_q[wptr_q] <= wdata;
         mem_last_q[wptr_q] <= last;
         mem_id_q[wptr_q]   <= id;
      end
   end

endmodule

// File: tb/tb_axi_wr_fifo_sink.sv
// Directed self-checking bench for axi_wr_fifo_sink (default DEPTH=8, window 0x100..0x10F).
module tb_axi_wr_fifo_sink;

   localparam logic [31:0] BASE = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        dv = 1'b0;
   logic [31:0] addr = '0;
   logic [0:0]  id = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        last = 1'b0;
   logic        hld, err;
   logic        flush = 1'b0;
   logic        o_valid;
   logic [31:0] o_data;
   logic        o_last;
   logic [0:0]  o_id;
`ifdef CALIPTRA_AXI_WR_FIFO_PARTIAL_EN
   logic [3:0]  o_strb;
`endif
   logic        i_ready = 1'b0;
   logic [3:0]  level;
   logic        full, empty;

   int n_pass = 0;
   int n_total = 0;

   axi_wr_fifo_sink dut (
      .clk(clk), .rst_n(rst_n), .dv(dv), .addr(addr), .id(id), .wdata(wdata),
      .wstrb(wstrb), .last(last), .hld(hld), .err(err), .flush(flush),
      .o_valid(o_valid), .o_data(o_data), .o_last(o_last), .o_id(o_id),
`ifdef CALIPTRA_AXI_WR_FIFO_PARTIAL_EN
      .o_strb(o_strb),
`endif
      .i_ready(i_ready), .level(level), .full(full), .empty(empty)
   );

   always #5 clk = ~clk;

   // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic l, input logic [0:0] i);
      dv = 1'b1; addr = a; wdata = d; wstrb = s; last = l; id = i;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      n_total++;
      if ({hld, err, o_valid, level, full, empty} !== {1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1})
         $display("FAIL reset: got hld=%b err=%b vld=%b lvl=%0d full=%b empty=%b, want 0 0 0 0 0 1",
                  hld, err, o_valid, level, full, empty);
      else n_pass++;
      tick(); tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      for (int i = 0; i < 3; i++) begin
         beat(BASE, 32'hA1 + 32'(i), 4'hF, i == 2, 1'(i));
         #1;
         n_total++;
         if (err !== 1'b0 || hld !== 1'b0)
            $display("FAIL basic_push%0d: got err=%b hld=%b, want 0 0", i, err, hld);
         else n_pass++;
         tick();
      end
      dv = 1'b0;
      n_total++;
      if (level !== 4'd3 || o_valid !== 1'b1)
         $display("FAIL basic_level: got level=%0d vld=%b, want 3 1", level, o_valid);
      else n_pass++;
      i_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         n_total++;
         if (o_data !== 32'hA1 + 32'(i) || o_last !== (i == 2) || o_id !== 1'(i))
            $display("FAIL basic_pop%0d: got data=%h last=%b id=%b, want %h %b %b",
                     i, o_data, o_last, o_id, 32'hA1 + 32'(i), i == 2, 1'(i));
         else n_pass++;
         tick();
      end
      i_ready = 1'b0;
      n_total++;
      if (empty !== 1'b1 || level !== 4'd0)
         $display("FAIL basic_empty: got empty=%b level=%0d, want 1 0", empty, level);
      else n_pass++;
   endtask

   task automatic test_full_stall();
      for (int i = 0; i < 8; i++) begin
         beat(BASE + 32'd4, 32'h10 + 32'(i), 4'hF, 1'b0, 1'b0);
         tick();
      end
      dv = 1'b0;
      n_total++;
      if (full !== 1'b1 || level !== 4'd8)
         $display("FAIL full_level: got full=%b level=%0d, want 1 8", full, level);
      else n_pass++;
      beat(BASE, 32'h99, 4'hF, 1'b1, 1'b1);
      #1;
      n_total++;
      if (hld !== 1'b1 || err !== 1'b0) $display("FAIL full_hld: got hld=%b err=%b, want 1 0", hld, err);
      else n_pass++;
      tick();
      i_ready = 1'b1;
      #1;
      n_total++;
      if (hld !== 1'b1) $display("FAIL full_hld_pop: got hld=%b, want 1", hld);
      else n_pass++;
      tick();
      i_ready = 1'b0;
      n_total++;
      if (hld !== 1'b0 || level !== 4'd7)
         $display("FAIL full_release: got hld=%b level=%0d, want 0 7", hld, level);
      else n_pass++;
      tick();
      dv = 1'b0;
      n_total++;
      if (level !== 4'd8) $display("FAIL full_9th: got level=%0d, want 8", level);
      else n_pass++;
   endtask

   task automatic test_bad_addr();
      beat(BASE + 32'd16, 32'hBAD, 4'hF, 1'b0, 1'b0);
      #1;
      n_total++;
      if (err !== 1'b1 || hld !== 1'b0)
         $display("FAIL bad_addr_full: got err=%b hld=%b, want 1 0", err, hld);
      else n_pass++;
      tick();
      dv = 1'b0;
      #1;
      n_total++;
      if (err !== 1'b0 || level !== 4'd8)
         $display("FAIL bad_addr_after: got err=%b level=%0d, want 0 8", err, level);
      else n_pass++;
      i_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         n_total++;
         if (o_data !== ((i == 7) ? 32'h99 : 32'h11 + 32'(i)))
            $display("FAIL drain%0d: got data=%h, want %h", i, o_data,
                     (i == 7) ? 32'h99 : 32'h11 + 32'(i));
         else n_pass++;
         tick();
      end
      i_ready = 1'b0;
      beat(BASE - 32'd4, 32'hBAD, 4'hF, 1'b0, 1'b0);
      #1;
      n_total++;
      if (err !== 1'b1 || hld !== 1'b0 || empty !== 1'b1)
         $display("FAIL bad_addr_low: got err=%b hld=%b empty=%b, want 1 0 1", err, hld, empty);
      else n_pass++;
      tick();
      dv = 1'b0;
      n_total++;
      if (level !== 4'd0) $display("FAIL bad_addr_nopush: got level=%0d, want 0", level);
      else n_pass++;
   endtask

   task automatic test_strobe();
      beat(BASE + 32'd8, 32'h33, 4'h3, 1'b0, 1'b0);
      #1;
`ifdef CALIPTRA_AXI_WR_FIFO_PARTIAL_EN
      n_total++;
      if (err !== 1'b0) $display("FAIL strb_part_err: got err=%b, want 0", err);
      else n_pass++;
      tick();
      beat(BASE + 32'd8, 32'h00, 4'h0, 1'b0, 1'b0);
      #1;
      n_total++;
      if (err !== 1'b0 || hld !== 1'b0) $display("FAIL strb_zero: got err=%b hld=%b, want 0 0", err, hld);
      else n_pass++;
      tick();
      dv = 1'b0;
      n_total++;
      if (level !== 4'd1 || o_strb !== 4'h3 || o_data !== 32'h33)
         $display("FAIL strb_part_push: got level=%0d strb=%h data=%h, want 1 3 33", level, o_strb, o_data);
      else n_pass++;
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
`else
      n_total++;
      if (err !== 1'b1 || hld !== 1'b0) $display("FAIL strb_part_err: got err=%b hld=%b, want 1 0", err, hld);
      else n_pass++;
      tick();
      beat(BASE + 32'd8, 32'h00, 4'h0, 1'b0, 1'b0);
      #1;
      n_total++;
      if (err !== 1'b1) $display("FAIL strb_zero: got err=%b, want 1", err);
      else n_pass++;
      tick();
      dv = 1'b0;
      n_total++;
      if (level !== 4'd0) $display("FAIL strb_nopush: got level=%0d, want 0", level);
      else n_pass++;
`endif
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         beat(BASE, 32'h40 + 32'(i), 4'hF, 1'b0, 1'b0);
         tick();
      end
      i_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         beat(BASE + 32'd12, 32'h44 + 32'(i), 4'hF, 1'b0, 1'b0);
         #1;
         n_total++;
         if (o_data !== 32'h40 + 32'(i) || hld !== 1'b0)
            $display("FAIL b2b_data%0d: got data=%h hld=%b, want %h 0", i, o_data, hld, 32'h40 + 32'(i));
         else n_pass++;
         tick();
         n_total++;
         if (level !== 4'd4) $display("FAIL b2b_level%0d: got level=%0d, want 4", i, level);
         else n_pass++;
      end
      dv = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_total++;
         if (o_data !== 32'h4A + 32'(i))
            $display("FAIL b2b_drain%0d: got data=%h, want %h", i, o_data, 32'h4A + 32'(i));
         else n_pass++;
         tick();
      end
      i_ready = 1'b0;
      n_total++;
      if (empty !== 1'b1) $display("FAIL b2b_empty: got empty=%b, want 1", empty);
      else n_pass++;
   endtask

   task automatic test_flush();
      for (int i = 0; i < 5; i++) begin
         beat(BASE, 32'h50 + 32'(i), 4'hF, 1'b0, 1'b0);
         tick();
      end
      beat(BASE, 32'h77, 4'hF, 1'b1, 1'b1);
      flush = 1'b1;
      i_ready = 1'b1;
      #1;
      n_total++;
      if (hld !== 1'b1 || err !== 1'b0 || level !== 4'd5)
         $display("FAIL flush_hld: got hld=%b err=%b level=%0d, want 1 0 5", hld, err, level);
      else n_pass++;
      tick();
      flush = 1'b0;
      i_ready = 1'b0;
      #1;
      n_total++;
      if (level !== 4'd0 || empty !== 1'b1 || hld !== 1'b0)
         $display("FAIL flush_clear: got level=%0d empty=%b hld=%b, want 0 1 0", level, empty, hld);
      else n_pass++;
      tick();
      dv = 1'b0;
      n_total++;
      if (level !== 4'd1 || o_data !== 32'h77 || o_last !== 1'b1)
         $display("FAIL flush_retry: got level=%0d data=%h last=%b, want 1 77 1", level, o_data, o_last);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      beat(BASE, 32'h61, 4'hF, 1'b0, 1'b0);
      tick();
      dv = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      n_total++;
      if (level !== 4'd0 || empty !== 1'b1 || o_valid !== 1'b0)
         $display("FAIL reset_mid: got level=%0d empty=%b vld=%b, want 0 1 0", level, empty, o_valid);
      else n_pass++;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full_stall();
      test_bad_addr();
      test_strobe();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
